// File: rtl/memory_arbiter.sv
// Serialises fetch, load and store requests onto one memory bus, one transaction at a time.
// Build option: define MEMORY_ARBITER_STARVATION_GUARD_EN to let a starved fetch jump the fixed priority.
module memory_arbiter #(
   parameter int AW           = 32,
   parameter int DW           = 32,
   parameter int TIMEOUT      = 255,
   parameter int STARVE_LIMIT = 4
) (
   input  logic          clock,
   input  logic          reset_n,
   input  logic          fetch_enable,
   input  logic [AW-1:0] fetch_address,
   output logic          fetch_valid,
   input  logic          load_enable,
   input  logic [AW-1:0] load_address,
   output logic          load_valid,
   input  logic          store_enable,
   input  logic [AW-1:0] store_address,
   input  logic [DW-1:0] store_data,
   output logic          store_valid,
   output logic [AW-1:0] mem_address,
   output logic [DW-1:0] mem_data_out,
   output logic          mem_read_enable,
   output logic          mem_write_enable,
   input  logic [DW-1:0] mem_data_in,
   input  logic          mem_data_valid,
   output logic [DW-1:0] read_data,
   output logic          timeout_error,
   output logic          busy,
   output logic [2:0]    debug_state
);

   // Handshake: a requester holds *_enable (and its address/data) until its *_valid
   // is seen high for one cycle; dropping *_enable before that aborts the request.

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } state_t;

   typedef enum logic [1:0] {
      GNT_NONE  = 2'd0,
      GNT_FETCH = 2'd1,
      GNT_LOAD  = 2'd2,
      GNT_STORE = 2'd3
   } grant_t;

   localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT - 1);

   if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_timeout
      $error("memory_arbiter: TIMEOUT out of range 1..65535");
   end
   if (STARVE_LIMIT < 1 || STARVE_LIMIT > 7) begin : g_bad_starve_limit
      $error("memory_arbiter: STARVE_LIMIT out of range 1..7");
   end

   state_t        state;
   grant_t        grant;
   grant_t        next_grant;
   logic [15:0]   timeout_count;
   logic          in_busy;
   logic          granted_enable;
   logic [AW-1:0] granted_address;
   logic          active;
   logic          timeout_hit;
   logic          complete;
   logic          any_request;
   logic          fetch_promoted;

   assign in_busy     = (state == ST_BUSY);
   assign any_request = fetch_enable | load_enable | store_enable;

   always_comb begin
      granted_enable  = 1'b0;
      granted_address = '0;
      case (grant)
         GNT_FETCH: begin
            granted_enable  = fetch_enable;
            granted_address = fetch_address;
         end
         GNT_LOAD: begin
            granted_enable  = load_enable;
            granted_address = load_address;
         end
         GNT_STORE: begin
            granted_enable  = store_enable;
            granted_address = store_address;
         end
         default: begin
            granted_enable  = 1'b0;
            granted_address = '0;
         end
      endcase
   end

`ifdef MEMORY_ARBITER_STARVATION_GUARD_EN
   logic [2:0] starve_count;

   assign fetch_promoted = (32'(starve_count) >= STARVE_LIMIT);

   // Counts IDLE arbitrations that fetch wanted but lost; saturates at 7.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         starve_count <= 3'd0;
      end else if (state == ST_IDLE && any_request) begin
         if (next_grant == GNT_FETCH) begin
            starve_count <= 3'd0;
         end else if (fetch_enable && starve_count != 3'd7) begin
            starve_count <= starve_count + 3'd1;
         end
      end
   end
`else
   assign fetch_promoted = 1'b0;
`endif

   always_comb begin
      next_grant = GNT_NONE;
      if (fetch_promoted && fetch_enable) begin
         next_grant = GNT_FETCH;
      end else if (store_enable) begin
         next_grant = GNT_STORE;
      end else if (load_enable) begin
         next_grant = GNT_LOAD;
      end else if (fetch_enable) begin
         next_grant = GNT_FETCH;
      end
   end

   // A response arriving on the timeout cycle wins: it is a normal completion.
   assign active      = in_busy && granted_enable;
   assign timeout_hit = active && !mem_data_valid && (timeout_count == TIMEOUT_LAST);
   assign complete    = active && (mem_data_valid || timeout_hit);

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state         <= ST_IDLE;
         grant         <= GNT_NONE;
         timeout_count <= 16'd0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (any_request) begin
                  state         <= ST_BUSY;
                  grant         <= next_grant;
                  timeout_count <= 16'd0;
               end
            end
            ST_BUSY: begin
               if (!granted_enable || complete) begin
                  state         <= ST_IDLE;
                  grant         <= GNT_NONE;
                  timeout_count <= 16'd0;
               end else begin
                  timeout_count <= timeout_count + 16'd1;
               end
            end
            default: begin
               state         <= ST_IDLE;
               grant         <= GNT_NONE;
               timeout_count <= 16'd0;
            end
         endcase
      end
   end

   assign mem_address      = in_busy ? granted_address : '0;
   assign mem_data_out     = (in_busy && grant == GNT_STORE) ? store_data : '0;
   assign mem_write_enable = in_busy && (grant == GNT_STORE) && store_enable;
   assign mem_read_enable  = in_busy && (((grant == GNT_LOAD) && load_enable) ||
                                         ((grant == GNT_FETCH) && fetch_enable));

   assign fetch_valid   = complete && (grant == GNT_FETCH);
   assign load_valid    = complete && (grant == GNT_LOAD);
   assign store_valid   = complete && (grant == GNT_STORE);
   assign timeout_error = timeout_hit;
   assign busy          = in_busy;
   assign read_data     = mem_data_in;
   assign debug_state   = {state, grant};

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter built with TIMEOUT=4 and STARVE_LIMIT=4.
module tb_memory_arbiter;

   logic        clock;
   logic        reset_n;
   logic        fetch_enable;
   logic [31:0] fetch_address;
   logic        fetch_valid;
   logic        load_enable;
   logic [31:0] load_address;
   logic        load_valid;
   logic        store_enable;
   logic [31:0] store_address;
   logic [31:0] store_data;
   logic        store_valid;
   logic [31:0] mem_address;
   logic [31:0] mem_data_out;
   logic        mem_read_enable;
   logic        mem_write_enable;
   logic [31:0] mem_data_in;
   logic        mem_data_valid;
   logic [31:0] read_data;
   logic        timeout_error;
   logic        busy;
   logic [2:0]  debug_state;

   int tests_run;
   int tests_failed;

   memory_arbiter #(
      .AW(32), .DW(32), .TIMEOUT(4), .STARVE_LIMIT(4)
   ) dut (
      .clock(clock), .reset_n(reset_n),
      .fetch_enable(fetch_enable), .fetch_address(fetch_address), .fetch_valid(fetch_valid),
      .load_enable(load_enable), .load_address(load_address), .load_valid(load_valid),
      .store_enable(store_enable), .store_address(store_address), .store_data(store_data),
      .store_valid(store_valid),
      .mem_address(mem_address), .mem_data_out(mem_data_out),
      .mem_read_enable(mem_read_enable), .mem_write_enable(mem_write_enable),
      .mem_data_in(mem_data_in), .mem_data_valid(mem_data_valid),
      .read_data(read_data), .timeout_error(timeout_error), .busy(busy),
      .debug_state(debug_state)
   );

   // clock / reset
   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // drive point: just after the active edge
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // sample point: opposite edge
   task automatic sample();
      @(negedge clock);
   endtask

   task automatic idle_inputs();
      fetch_enable   = 1'b0;
      load_enable    = 1'b0;
      store_enable   = 1'b0;
      mem_data_valid = 1'b0;
   endtask

   logic [2:0] exp_vld [6];
   int         store_cnt;
   int         fetch_cnt;
   int         wr_cycles;

   initial begin
      tests_run     = 0;
      tests_failed  = 0;
      reset_n       = 1'b0;
      idle_inputs();
      fetch_address = 32'h0000_0200;
      load_address  = 32'h0000_0040;
      store_address = 32'h0000_0100;
      store_data    = 32'hDEAD_BEEF;
      mem_data_in   = 32'h0;
      repeat (3) tick();

      // reset state
      sample();
      check_eq("rst_busy", {31'b0, busy}, 32'd0);
      check_eq("rst_strobes", {30'b0, mem_read_enable, mem_write_enable}, 32'd0);
      check_eq("rst_addr", mem_address, 32'd0);
      check_eq("rst_debug", {29'b0, debug_state}, 32'd0);
      tick();
      reset_n = 1'b1;

      // single store, response in the 3rd BUSY cycle
      tick();
      store_enable = 1'b1;
      sample();
      check_eq("st_idle_no_strobe", {31'b0, mem_write_enable}, 32'd0);
      wr_cycles = 0;
      for (int c = 1; c <= 3; c++) begin
         tick();
         if (c == 3) mem_data_valid = 1'b1;
         sample();
         if (mem_write_enable) wr_cycles++;
         check_eq("st_addr", mem_address, 32'h100);
         check_eq("st_valid", {31'b0, store_valid}, (c == 3) ? 32'd1 : 32'd0);
      end
      check_eq("st_data_out", mem_data_out, 32'hDEAD_BEEF);
      check_eq("st_wr_cycles", wr_cycles, 32'd3);
      tick();
      idle_inputs();
      sample();
      check_eq("st_back_idle", {30'b0, busy, store_valid}, 32'd0);

      // all three at once, 1-cycle memory: store, load, fetch with idle gaps
      exp_vld = '{3'b000, 3'b100, 3'b000, 3'b010, 3'b000, 3'b001};
      tick();
      fetch_enable   = 1'b1;
      load_enable    = 1'b1;
      store_enable   = 1'b1;
      mem_data_valid = 1'b1;
      for (int c = 0; c < 6; c++) begin
         sample();
         check_eq($sformatf("order_c%0d", c), {29'b0, store_valid, load_valid, fetch_valid},
                  {29'b0, exp_vld[c]});
         tick();
         if (exp_vld[c][2]) store_enable = 1'b0;
         if (exp_vld[c][1]) load_enable  = 1'b0;
         if (exp_vld[c][0]) fetch_enable = 1'b0;
      end
      idle_inputs();

      // load returning data
      load_enable = 1'b1;
      tick();
      mem_data_valid = 1'b1;
      mem_data_in    = 32'h1234_5678;
      sample();
      check_eq("ld_valid", {31'b0, load_valid}, 32'd1);
      check_eq("ld_data", read_data, 32'h1234_5678);
      check_eq("ld_fetch_quiet", {31'b0, fetch_valid}, 32'd0);
      check_eq("ld_addr", mem_address, 32'h40);
      check_eq("ld_rd_en", {31'b0, mem_read_enable}, 32'd1);
      tick();
      idle_inputs();

      // timeout: store with no response for 4 BUSY cycles
      tick();
      store_enable = 1'b1;
      for (int c = 1; c <= 4; c++) begin
         tick();
         sample();
         check_eq($sformatf("to_valid_c%0d", c), {31'b0, store_valid}, (c == 4) ? 32'd1 : 32'd0);
         check_eq($sformatf("to_err_c%0d", c), {31'b0, timeout_error}, (c == 4) ? 32'd1 : 32'd0);
      end
      tick();
      store_enable = 1'b0;
      sample();
      check_eq("to_busy_fall", {31'b0, busy}, 32'd0);

      // response on the timeout cycle is a normal completion
      tick();
      store_enable = 1'b1;
      for (int c = 1; c <= 4; c++) begin
         tick();
         if (c == 4) mem_data_valid = 1'b1;
      end
      sample();
      check_eq("to_race_valid", {31'b0, store_valid}, 32'd1);
      check_eq("to_race_err", {31'b0, timeout_error}, 32'd0);
      tick();
      idle_inputs();

      // abort: load drops in 2nd BUSY cycle, pending fetch served next
      tick();
      load_enable  = 1'b1;
      fetch_enable = 1'b1;
      tick();
      sample();
      check_eq("ab_rd_en_c1", {31'b0, mem_read_enable}, 32'd1);
      tick();
      load_enable = 1'b0;
      sample();
      check_eq("ab_rd_en_drop", {31'b0, mem_read_enable}, 32'd0);
      check_eq("ab_no_valid", {29'b0, load_valid, fetch_valid, timeout_error}, 32'd0);
      tick();
      sample();
      check_eq("ab_idle", {31'b0, busy}, 32'd0);
      tick();
      mem_data_valid = 1'b1;
      sample();
      check_eq("ab_fetch_addr", mem_address, 32'h200);
      check_eq("ab_fetch_valid", {31'b0, fetch_valid}, 32'd1);
      tick();
      idle_inputs();

      // continuous store traffic with fetch waiting
      tick();
      store_enable   = 1'b1;
      fetch_enable   = 1'b1;
      mem_data_valid = 1'b1;
      store_cnt = 0;
      fetch_cnt = 0;
      for (int c = 0; c < 10; c++) begin
         sample();
         if (store_valid) store_cnt++;
         if (fetch_valid) fetch_cnt++;
         tick();
      end
`ifdef MEMORY_ARBITER_STARVATION_GUARD_EN
      check_eq("sv_store_cnt", store_cnt, 32'd4);
      check_eq("sv_fetch_cnt", fetch_cnt, 32'd1);
`else
      check_eq("sv_store_cnt", store_cnt, 32'd5);
      check_eq("sv_fetch_cnt", fetch_cnt, 32'd0);
`endif
      store_enable = 1'b0;
      tick();
      sample();
      check_eq("sv_fetch_after", {31'b0, fetch_valid}, 32'd1);
      tick();
      idle_inputs();

      // asynchronous reset in the middle of BUSY
      tick();
      store_enable = 1'b1;
      tick();
      #2;
      reset_n = 1'b0;
      #1;
      check_eq("ar_strobe", {31'b0, mem_write_enable}, 32'd0);
      check_eq("ar_busy", {31'b0, busy}, 32'd0);
      check_eq("ar_debug", {29'b0, debug_state}, 32'd0);
      idle_inputs();
      tick();
      reset_n = 1'b1;
      tick();

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
